insert_fifo: RTL and testbench

INSERT_FIFO -- requirements
Module: insert_fifo

---
 rtl/insert_fifo_if.sv | 31 +++
 rtl/insert_fifo.sv | 95 +++++++++
 tb/tb_insert_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/insert_fifo_if.sv
// insert_fifo_if -- handshake bundle between the AES-side producer, the byte
// serializer and the downstream byte FIFO.
//   load  : producer -> serializer, request to hand over a block
//   in    : producer -> serializer, block (in[top:top-7] is byte 0)
//   full  : FIFO -> serializer, no write may happen this cycle
//   push  : serializer -> FIFO, write strobe, one byte per cycle
//   data  : serializer -> FIFO, byte presented with push
//   ready : serializer -> producer, a load this cycle is accepted
//   done  : serializer -> producer, one-cycle pulse after the last byte
// master = producer/FIFO side, slave = serializer.
interface insert_fifo_if #(
  parameter int BLOCK_BYTES = 16
);
  logic                       load;
  logic [8*BLOCK_BYTES-1:0]   in;
  logic                       full;
  logic                       push;
  logic [7:0]                 data;
  logic                       ready;
  logic                       done;

  modport master (
    output load, in, full,
    input  push, data, ready, done
  );

  modport slave (
    input  load, in, full,
    output push, data, ready, done
  );
endinterface

// File: rtl/insert_fifo.sv
// insert_fifo -- accepts a BLOCK_BYTES-wide block and writes it byte by byte,
// most significant byte first, into a downstream byte FIFO, stalling while
// the FIFO reports full.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : insert_fifo_if.slave (load/in/full in, push/data/ready/done out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for load; ready high once out of reset
// ST_SEND | one byte offered per cycle, held while full is high
// ST_DONE | single-cycle done pulse, then back to ST_IDLE
module insert_fifo #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic          clk,
  input  logic          n_rst,
  insert_fifo_if.slave  bus
);
  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   shift_reg, shift_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           armed;

  // The first edge after reset release only arms the block, so a load that
  // coincides with the release edge is never taken.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.load && armed) begin
          shift_nxt = bus.in;
          cnt_nxt   = '0;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.full) begin
          shift_nxt = {shift_reg[W-9:0], 8'h00};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // push follows full combinationally so the FIFO never sees a write
  // in a cycle it reports full.
  assign bus.push  = (state == ST_SEND) && !bus.full;
  assign bus.data  = (state == ST_SEND) ? shift_reg[W-1:W-8] : 8'h00;
  assign bus.ready = (state == ST_IDLE) && armed;
  assign bus.done  = (state == ST_DONE);
endmodule

// File: tb/tb_insert_fifo.sv
// tb_insert_fifo -- randomized and directed stimulus for insert_fifo, checked
// every cycle against a queue-based reference model of the byte stream.
module tb_insert_fifo;
  logic clk;
  logic n_rst;

  insert_fifo_if #(.BLOCK_BYTES(16)) bus ();

  insert_fifo #(.BLOCK_BYTES(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miscomp;

  // reference model: bytes still owed to the FIFO, pending done pulse,
  // and whether the first edge after reset release has passed
  logic [7:0] pend[$];
  logic       done_due;
  logic       armed;

  logic       obs_push, obs_done, obs_ready;

  localparam logic [127:0] IN1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] INA = {16{8'hA5}};
  localparam logic [127:0] IN3 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] INF = {16{8'hFF}};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscomp++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    done_due = 1'b0;
    armed    = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [127:0] din, input logic fl);
    logic       e_push, e_done, e_ready;
    logic [7:0] e_data;
    @(negedge clk);
    n_rst    = 1'b1;
    bus.load = ld;
    bus.in   = din;
    bus.full = fl;
    #1;
    e_push  = (pend.size() > 0) && !fl;
    e_data  = (pend.size() > 0) ? pend[0] : 8'h00;
    e_done  = done_due;
    e_ready = (pend.size() == 0) && !done_due && armed;
    check_val("push",  32'(bus.push),  32'(e_push));
    check_val("data",  32'(bus.data),  32'(e_data));
    check_val("done",  32'(bus.done),  32'(e_done));
    check_val("ready", 32'(bus.ready), 32'(e_ready));
    obs_push  = bus.push;
    obs_done  = bus.done;
    obs_ready = bus.ready;
    @(posedge clk);
    if (done_due) begin
      done_due = 1'b0;
    end else if (pend.size() > 0) begin
      if (!fl) begin
        void'(pend.pop_front());
        if (pend.size() == 0) done_due = 1'b1;
      end
    end else if (armed && ld) begin
      for (int b = 0; b < 16; b++) pend.push_back(din[127-8*b -: 8]);
    end
    armed = 1'b1;
  endtask

  // asserts reset mid-cycle and leaves it asserted; the next step releases it
  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_val("rst_push",  32'(bus.push),  32'd0);
    check_val("rst_data",  32'(bus.data),  32'd0);
    check_val("rst_done",  32'(bus.done),  32'd0);
    check_val("rst_ready", 32'(bus.ready), 32'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    int pc, dc, di, lp, d1, d2, nd;
    n_vec     = 0;
    n_miscomp = 0;
    n_rst     = 1'b0;
    bus.load  = 1'b0;
    bus.in    = '0;
    bus.full  = 1'b0;
    model_clear();
    #1;
    check_val("init_push",  32'(bus.push),  32'd0);
    check_val("init_data",  32'(bus.data),  32'd0);
    check_val("init_ready", 32'(bus.ready), 32'd0);
    check_val("init_done",  32'(bus.done),  32'd0);
    repeat (2) @(posedge clk);

    // load presented on the release edge must be ignored
    step(1'b1, IN1, 1'b0);
    step(1'b0, IN1, 1'b0);
    check_val("rel_load_ignored", 32'(obs_push), 32'd0);
    check_val("rel_ready", 32'(obs_ready), 32'd1);

    // plain block, no back-pressure
    step(1'b1, IN1, 1'b0);
    pc = 0; dc = 0;
    for (int i = 1; i <= 18; i++) begin
      step(1'b0, 128'h0, 1'b0);
      if (obs_push) pc++;
      if (obs_done) dc = i;
      if (i == 18) check_val("plain_ready18", 32'(obs_ready), 32'd1);
    end
    check_val("plain_pushes", pc, 16);
    check_val("plain_done_cyc", dc, 17);

    // stall for cycles 3..7 after the load
    step(1'b1, IN1, 1'b0);
    pc = 0; nd = 0;
    for (int i = 1; i <= 25; i++) begin
      step(1'b0, 128'h0, (i >= 3 && i <= 7));
      if (obs_push) pc++;
      if (obs_done) nd++;
    end
    check_val("stall_pushes", pc, 16);
    check_val("stall_dones", nd, 1);

    // full toggling every cycle
    step(1'b1, INF, 1'b0);
    pc = 0; nd = 0; di = 0; lp = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 128'h0, (i % 2) == 1);
      if (obs_push) begin pc++; lp = i; end
      if (obs_done) begin nd++; di = i; end
    end
    check_val("toggle_pushes", pc, 16);
    check_val("toggle_dones", nd, 1);
    check_val("toggle_done_gap", di - lp, 1);

    // second load during SEND is ignored
    step(1'b1, IN1, 1'b0);
    pc = 0;
    for (int i = 1; i <= 20; i++) begin
      step(i == 5, INA, 1'b0);
      if (obs_push) pc++;
    end
    check_val("ign_pushes", pc, 16);

    // reset after the 5th push, then a fresh block
    step(1'b1, IN1, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 128'h0, 1'b0);
    do_reset();
    step(1'b0, 128'h0, 1'b0);
    step(1'b1, IN3, 1'b0);
    check_val("post_rst_ready", 32'(obs_ready), 32'd1);
    pc = 0;
    for (int i = 1; i <= 18; i++) begin
      step(1'b0, 128'h0, 1'b0);
      if (obs_push) pc++;
    end
    check_val("post_rst_pushes", pc, 16);

    // load held high: done every 18 cycles
    d1 = -1; d2 = -1; nd = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, IN3, 1'b0);
      if (obs_done) begin
        if (nd == 0) d1 = i;
        else if (nd == 1) d2 = i;
        nd++;
      end
    end
    check_val("b2b_period", d2 - d1, 18);
    for (int i = 0; i < 20; i++) step(1'b0, 128'h0, 1'b0);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0,
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 2) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end
endmodule
